// File: rtl/aes_io_pkg.sv
// Shared constants for the AES top's user I/O: display geometry and the
// active-low 7-segment glyphs for hex digits, bit order {g,f,e,d,c,b,a}.
package aes_io_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int SEG_W      = 7;
    localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] HEX7_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] HEX7_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] HEX7_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] HEX7_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] HEX7_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] HEX7_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] HEX7_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] HEX7_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] HEX7_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] HEX7_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] HEX7_A = 7'b0001000;
    localparam logic [SEG_W-1:0] HEX7_B = 7'b0000011;
    localparam logic [SEG_W-1:0] HEX7_C = 7'b1000110;
    localparam logic [SEG_W-1:0] HEX7_D = 7'b0100001;
    localparam logic [SEG_W-1:0] HEX7_E = 7'b0000110;
    localparam logic [SEG_W-1:0] HEX7_F = 7'b0001110;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import aes_io_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_n_o = HEX7_0;
            4'h1: seg_n_o = HEX7_1;
            4'h2: seg_n_o = HEX7_2;
            4'h3: seg_n_o = HEX7_3;
            4'h4: seg_n_o = HEX7_4;
            4'h5: seg_n_o = HEX7_5;
            4'h6: seg_n_o = HEX7_6;
            4'h7: seg_n_o = HEX7_7;
            4'h8: seg_n_o = HEX7_8;
            4'h9: seg_n_o = HEX7_9;
            4'hA: seg_n_o = HEX7_A;
            4'hB: seg_n_o = HEX7_B;
            4'hC: seg_n_o = HEX7_C;
            4'hD: seg_n_o = HEX7_D;
            4'hE: seg_n_o = HEX7_E;
            4'hF: seg_n_o = HEX7_F;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/user_output_display.sv
// Latches a 16-bit result and scans it as 4 hex digits on a multiplexed
// common-anode display; frame_done marks one complete showing of a fresh word.
module user_output_display
    import aes_io_pkg::*;
#(
    parameter  int REFRESH_DIV = 50000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              hold,
    input  logic              blank,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [SEG_W-1:0]  seg_n,
    output logic              dp_n,
    output logic [WORD_W-1:0] disp_reg,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] DIV_MAX    = CNT_W'(REFRESH_DIV - 1);
    localparam digit_idx_t       LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      div_q, div_d;
    digit_idx_t            idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [WORD_W-1:0]     disp_q, disp_d;
    logic                  fd_q, fd_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NIBBLE_W-1:0]   nibble;
    logic [SEG_W-1:0]      hex_seg;
    logic                  latch;
    logic                  wrap;

    assign latch = data_valid && !hold;
    assign wrap  = (div_q == DIV_MAX);

    // A new latch takes priority over the digit wrap, so a word replaced on its
    // final edge never reports frame_done.
    always_comb begin
        disp_d    = disp_q;
        div_d     = div_q + 1'b1;
        idx_d     = idx_q;
        pending_d = pending_q;
        fd_d      = 1'b0;
        if (latch) begin
            disp_d    = data_in;
            div_d     = '0;
            idx_d     = '0;
            pending_d = 1'b1;
        end else if (wrap) begin
            div_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_DIGIT && pending_q) begin
                pending_d = 1'b0;
                fd_d      = 1'b1;
            end
        end
    end

    always_comb begin
        nibble = disp_q[3:0];
        case (idx_q)
            2'd1:    nibble = disp_q[7:4];
            2'd2:    nibble = disp_q[11:8];
            2'd3:    nibble = disp_q[15:12];
            default: nibble = disp_q[3:0];
        endcase
    end

    hex_to_7seg u_hex (
        .nibble_i (nibble),
        .seg_n_o  (hex_seg)
    );

    always_comb begin
        an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        seg_d = blank ? SEG_BLANK : hex_seg;
        dp_d  = ~(hold && (idx_q == LAST_DIGIT) && !blank);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            disp_q    <= '0;
            fd_q      <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            disp_q    <= disp_d;
            fd_q      <= fd_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign disp_reg   = disp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_user_output_display.sv
// Directed bench for user_output_display with a 4-cycle digit period.
module tb_user_output_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data_in = 16'h0;
    logic        data_valid = 1'b0;
    logic        hold = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [15:0] disp_reg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int since_latch = 0;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    user_output_display #(.REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .hold       (hold),
        .blank      (blank),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .disp_reg   (disp_reg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        since_latch++;
    endtask

    // Outputs seen after edge k+c show the digit selected after edge k+c-1.
    task automatic check_scan(input string tag, input logic [15:0] word, input int frame_at);
        int         dig;
        logic [3:0] nib;
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;
        check({tag, ":disp"}, 32'(disp_reg), 32'(word));
        check({tag, ":frame_done"}, 32'(frame_done), 32'(since_latch == frame_at));
        if (since_latch >= 1) begin
            dig     = ((since_latch - 1) / RD) % 4;
            nib     = 4'((word >> (4 * dig)) & 16'hF);
            an_exp  = blank ? 4'hF : ~(4'b0001 << dig);
            seg_exp = blank ? 7'h7F : hex_tbl[nib];
            dp_exp  = !(hold && dig == 3 && !blank);
            check({tag, ":an_n"}, 32'(an_n), 32'(an_exp));
            check({tag, ":seg_n"}, 32'(seg_n), 32'(seg_exp));
            check({tag, ":dp_n"}, 32'(dp_n), 32'(dp_exp));
        end
    endtask

    task automatic run(input int n, input string tag, input logic [15:0] word, input int frame_at);
        for (int i = 0; i < n; i++) begin
            step();
            check_scan(tag, word, frame_at);
        end
    endtask

    task automatic latch(input logic [15:0] d);
        data_in    = d;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        if (!hold) since_latch = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ":an_n"}, 32'(an_n), 32'hF);
        check({tag, ":seg_n"}, 32'(seg_n), 32'h7F);
        check({tag, ":dp_n"}, 32'(dp_n), 32'h1);
        check({tag, ":disp"}, 32'(disp_reg), 32'h0);
        check({tag, ":frame_done"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        since_latch = 0;
        run(6, "idle", 16'h0000, -1);

        // Scan order and frame_done timing; no pulse in the second frame.
        latch(16'hA5F0);
        check_scan("a5f0_latch", 16'hA5F0, 16);
        run(33, "a5f0", 16'hA5F0, 16);

        // Frozen display: strobe dropped, dot on leftmost digit.
        hold = 1'b1;
        latch(16'h1234);
        check_scan("hold_latch", 16'hA5F0, 16);
        run(20, "hold", 16'hA5F0, 16);
        hold = 1'b0;
        run(4, "unhold", 16'hA5F0, 16);

        // Re-latch while idx==2: only the second word reports.
        latch(16'h1111);
        run(9, "w1111", 16'h1111, -1);
        latch(16'h2222);
        check_scan("w2222_latch", 16'h2222, 16);
        run(20, "w2222", 16'h2222, 16);

        // Latch on the final wrap edge of a pending frame: latch wins.
        latch(16'hBEEF);
        run(15, "beef", 16'hBEEF, -1);
        latch(16'hC0DE);
        check_scan("c0de_latch", 16'hC0DE, 16);
        run(18, "c0de", 16'hC0DE, 16);

        // Blank across a latch: scan and frame_done carry on.
        blank = 1'b1;
        latch(16'hFFFF);
        check_scan("blank_latch", 16'hFFFF, 16);
        run(20, "blank", 16'hFFFF, 16);
        blank = 1'b0;
        run(6, "unblank", 16'hFFFF, 16);

        // Asynchronous reset mid-frame loses the pending pulse.
        latch(16'h1234);
        run(6, "pre_rst", 16'h1234, 16);
        rst_n = 1'b0;
        #2 check_reset("async_rst");
        repeat (3) @(posedge clk);
        #1 check_reset("rst_held");
        #1 rst_n = 1'b1;
        since_latch = 0;
        run(24, "post_rst", 16'h0000, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
